// File: rtl/cpu_bus_fabric_if.sv
// CPU-side bus bundle between the RV32 core and cpu_bus_fabric.
// The fabric connects to the slave modport; the CPU model or bench drives the master side.
interface cpu_bus_fabric_if #(
    parameter int unsigned NumSlaves     = 8,
    parameter int unsigned address_width = 32,
    parameter int unsigned data_width    = 32
) ();
    logic [address_width-1:0] cpu_address_i;
    logic                     cpu_valid_i;
    logic                     cpu_we_i;
    logic [data_width-1:0]    slave_data_i [NumSlaves];
    logic [NumSlaves-1:0]     slave_sel_o;
    logic [data_width-1:0]    cpu_data_o;
    logic                     cpu_halt_o;

    modport master (
        output cpu_address_i, cpu_valid_i, cpu_we_i, slave_data_i,
        input  slave_sel_o, cpu_data_o, cpu_halt_o
    );

    modport slave (
        input  cpu_address_i, cpu_valid_i, cpu_we_i, slave_data_i,
        output slave_sel_o, cpu_data_o, cpu_halt_o
    );
endinterface

// File: rtl/cpu_bus_fabric.sv
// N-slave address decoder with per-slave read wait states, unmapped-access error capture
// and power-on reset sequencer. Optional IRQ aggregation: define CPU_BUS_FABRIC_IRQ_EN.
module cpu_bus_fabric #(
    parameter int unsigned NumSlaves     = 8,
    parameter int unsigned address_width = 32,
    parameter int unsigned data_width    = 32,
    parameter logic [address_width-1:0] SlaveBase [NumSlaves] = '{default: '0},
    parameter logic [address_width-1:0] SlaveEnd  [NumSlaves] = '{default: '0},
    parameter logic [3:0] SlaveWaitStates [NumSlaves] = '{default: 4'd0},
    parameter int unsigned ResetHoldCycles = 5,
    parameter logic [data_width-1:0] ErrorData = 32'hDEAD_BEEF,
    parameter logic [NumSlaves-1:0] IrqMask = '1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    cpu_bus_fabric_if.slave          bus,
    output logic                     cpu_reset_o,
    output logic                     err_o,
    output logic [address_width-1:0] err_addr_o,
    input  logic [NumSlaves-1:0]     irq_i,
    output logic                     irq_o
);
    localparam int unsigned IdxW    = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
    localparam int unsigned RstCntW = $clog2(ResetHoldCycles + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR
    } state_t;

    state_t                   state_q;
    logic [3:0]               wait_cnt_q;
    logic [IdxW-1:0]          slave_idx_q;
    logic [data_width-1:0]    cpu_data_q;
    logic                     err_q;
    logic                     err_seen_q;
    logic [address_width-1:0] err_addr_q;
    logic                     cpu_reset_q;
    logic                     cpu_reset_d;
    logic [RstCntW-1:0]       rst_cnt_q;
    logic [RstCntW-1:0]       rst_cnt_d;
    logic                     irq_q;

    logic            hit;
    logic [IdxW-1:0] hit_idx;
    logic [3:0]      hit_ws;
    logic            req_read;

    // Scan from the top so the lowest matching window wins on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NumSlaves - 1; k >= 0; k--) begin
            if (bus.cpu_address_i >= SlaveBase[k] && bus.cpu_address_i <= SlaveEnd[k]) begin
                hit     = 1'b1;
                hit_idx = IdxW'(k);
            end
        end
    end

    assign hit_ws          = SlaveWaitStates[hit_idx];
    assign bus.slave_sel_o = hit ? (NumSlaves'(1) << hit_idx) : '0;
    assign req_read        = !cpu_reset_q && (state_q == ST_IDLE) && bus.cpu_valid_i
                             && !bus.cpu_we_i && hit;

    assign bus.cpu_halt_o = (req_read && (hit_ws != 4'd0))
                            || (!cpu_reset_q && (state_q == ST_WAIT) && (wait_cnt_q != 4'd0));

    always_comb begin
        rst_cnt_d   = rst_cnt_q;
        cpu_reset_d = cpu_reset_q;
        if (cpu_reset_q) begin
            if (int'(rst_cnt_q) + 1 >= ResetHoldCycles) begin
                cpu_reset_d = 1'b0;
            end else begin
                rst_cnt_d = rst_cnt_q + RstCntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rst_cnt_q   <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            rst_cnt_q   <= rst_cnt_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    // A single wait state is covered by the request-cycle halt alone, so W=1 captures
    // directly from IDLE; longer waits finish in WAIT when the counter reaches 1.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            slave_idx_q <= '0;
            cpu_data_q  <= '0;
            err_q       <= 1'b0;
            err_seen_q  <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_q <= 1'b0;
            if (cpu_reset_q) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.cpu_valid_i) begin
                            if (!hit) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                                if (!err_seen_q) begin
                                    err_seen_q <= 1'b1;
                                    err_addr_q <= bus.cpu_address_i;
                                end
                                if (!bus.cpu_we_i) begin
                                    cpu_data_q <= ErrorData;
                                end
                            end else if (!bus.cpu_we_i) begin
                                if (hit_ws <= 4'd1) begin
                                    cpu_data_q <= bus.slave_data_i[hit_idx];
                                end else begin
                                    state_q     <= ST_WAIT;
                                    wait_cnt_q  <= hit_ws - 4'd1;
                                    slave_idx_q <= hit_idx;
                                end
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (wait_cnt_q <= 4'd1) begin
                            cpu_data_q <= bus.slave_data_i[slave_idx_q];
                            wait_cnt_q <= 4'd0;
                            state_q    <= ST_IDLE;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 4'd1;
                        end
                    end
                    ST_ERR: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CPU_BUS_FABRIC_IRQ_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(irq_i & IrqMask);
        end
    end
`else
    logic unused_irq;
    assign unused_irq = ^{irq_i, IrqMask};
    assign irq_q      = 1'b0;
`endif

    assign bus.cpu_data_o = cpu_data_q;
    assign cpu_reset_o    = cpu_reset_q;
    assign err_o          = err_q;
    assign err_addr_o     = err_addr_q;
    assign irq_o          = irq_q;
endmodule
